apb_gpio_bank: RTL and testbench

APB slave holding one bank of GPIO pins: output, direction, input-sample and edge-interrupt registers. Sits directly downstream of the SPI-to-APB bridge. Each bank is selected by one bit of the bridge's `b_psel` bus and shares its `pclk`/`presetn`, `pwrite`, `penable`, `paddr` and `pwdata`. Its `prdata` and `pready` return to the bridge.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_sync_edge.sv | 34 +++
 rtl/apb_gpio_bank.sv | 140 ++++++++++++++
 tb/tb_apb_gpio_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO bank: register map and APB slave FSM encoding.
package gpio_pkg;

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IN       = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd5;
    localparam logic [2:0] ADDR_OUT_TGL  = 3'd6;
    localparam logic [2:0] ADDR_ID       = 3'd7;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETUP       = 2'd1,
        ACCESS_WAIT = 2'd2,
        ACCESS_RDY  = 2'd3
    } apb_state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pad inputs, plus one delay stage
// so rising/falling edges can be detected on the synchronized value.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB slave for one GPIO bank: output/direction registers, synchronized input
// sampling and sticky edge interrupts. Every transfer takes one wait cycle.
module apb_gpio_bank
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BANK_ID    = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    apb_state_t            state;
    apb_state_t            state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            reg_sel;
    logic                  commit;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] dir_q;
    logic [DATA_WIDTH-1:0] rise_en_q;
    logic [DATA_WIDTH-1:0] fall_en_q;
    logic [DATA_WIDTH-1:0] irq_stat_q;
    logic [DATA_WIDTH-1:0] irq_stat_next;
    logic [DATA_WIDTH-1:0] irq_clr;

    logic [DATA_WIDTH-1:0] pin_sync;
    logic [DATA_WIDTH-1:0] pin_rise;
    logic [DATA_WIDTH-1:0] pin_fall;

    gpio_sync_edge #(.WIDTH(DATA_WIDTH)) u_sync (
        .clk     (pclk),
        .rst_n   (presetn),
        .async_in(gpio_in),
        .sync    (pin_sync),
        .rise    (pin_rise),
        .fall    (pin_fall)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (psel && !penable) state_next = SETUP;
            SETUP:       if (!psel) state_next = IDLE;
                         else if (penable) state_next = ACCESS_WAIT;
            ACCESS_WAIT: state_next = psel ? ACCESS_RDY : IDLE;
            ACCESS_RDY:  state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // The transfer completes on the edge leaving the wait cycle; losing psel there abandons it.
    assign commit  = (state == ACCESS_WAIT) && psel;
    assign wr_en   = commit && write_q;
    assign rd_en   = commit && !write_q;
    assign reg_sel = 3'(addr_q);

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            ADDR_OUT:      rd_mux = out_q;
            ADDR_DIR:      rd_mux = dir_q;
            ADDR_IN:       rd_mux = pin_sync;
            ADDR_RISE_EN:  rd_mux = rise_en_q;
            ADDR_FALL_EN:  rd_mux = fall_en_q;
            ADDR_IRQ_STAT: rd_mux = irq_stat_q;
            ADDR_ID:       rd_mux = DATA_WIDTH'(BANK_ID);
            default:       rd_mux = '0;
        endcase
    end

    // New edge events take priority over a simultaneous write-1-to-clear.
    always_comb begin
        irq_clr = '0;
        if (wr_en && reg_sel == ADDR_IRQ_STAT) irq_clr = pwdata;
        irq_stat_next = (irq_stat_q & ~irq_clr) | (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            pready  <= 1'b0;
            prdata  <= '0;
        end else begin
            state  <= state_next;
            pready <= commit;
            prdata <= rd_en ? rd_mux : '0;
            if (state == IDLE && psel && !penable) begin
                addr_q  <= paddr;
                write_q <= pwrite;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            out_q      <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_stat_q <= '0;
            irq        <= 1'b0;
        end else begin
            irq_stat_q <= irq_stat_next;
            irq        <= |irq_stat_next;
            if (wr_en) begin
                case (reg_sel)
                    ADDR_OUT:     out_q     <= pwdata;
                    ADDR_DIR:     dir_q     <= pwdata;
                    ADDR_RISE_EN: rise_en_q <= pwdata;
                    ADDR_FALL_EN: fall_en_q <= pwdata;
                    ADDR_OUT_TGL: out_q     <= out_q ^ pwdata;
                    default:      ;
                endcase
            end
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Self-checking bench for apb_gpio_bank: read expectations are queued when a
// read is issued and popped when the DUT presents pready.
module tb_apb_gpio_bank;

    localparam int BANK = 'h42;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       irq;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 pclk = ~pclk;

    apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BANK_ID(BANK)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    // One full APB transfer; optionally changes the pins in the setup cycle.
    task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] d,
                        input logic pin_chg, input logic [7:0] pin_val, input string tag);
        int         cyc;
        logic [7:0] exp;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        if (pin_chg) gpio_in = pin_val;
        @(negedge pclk);
        penable = 1'b1;
        cyc = 1;
        while (!pready && cyc < 8) begin
            @(negedge pclk);
            cyc++;
        end
        n_cmp++;
        if (cyc != 3) begin
            n_bad++;
            $display("[TB] FAIL %s pready_cycle got %0d want 3", tag, cyc);
        end
        if (!wr) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (!pready || prdata !== exp) begin
                n_bad++;
                $display("[TB] FAIL %s prdata got %02h (pready %b) want %02h", tag, prdata, pready, exp);
            end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [2:0] a, input logic [7:0] d, input string tag);
        xfer(1'b1, a, d, 1'b0, 8'h00, tag);
    endtask

    task automatic apb_rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        exp_q.push_back(exp);
        xfer(1'b0, a, 8'h00, 1'b0, 8'h00, tag);
    endtask

    task automatic test_reset();
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        repeat (3) @(negedge pclk);
        n_cmp++;
        if ({prdata, pready, irq, gpio_out, gpio_oe} !== 26'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs got prdata=%02h pready=%b irq=%b out=%02h oe=%02h want all 0",
                     prdata, pready, irq, gpio_out, gpio_oe);
        end
        presetn = 1'b1;
        for (int i = 0; i < 7; i++) apb_rd(3'(i), 8'h00, $sformatf("reset_rd%0d", i));
        apb_rd(3'd7, 8'(BANK), "reset_id");
    endtask

    task automatic test_out_dir();
        apb_wr(3'd1, 8'hF0, "wr_dir");
        n_cmp++;
        if (gpio_oe !== 8'hF0) begin
            n_bad++;
            $display("[TB] FAIL gpio_oe got %02h want f0", gpio_oe);
        end
        apb_wr(3'd0, 8'h5A, "wr_out");
        n_cmp++;
        if (gpio_out !== 8'h5A) begin
            n_bad++;
            $display("[TB] FAIL gpio_out got %02h want 5a", gpio_out);
        end
        apb_wr(3'd6, 8'hFF, "wr_tgl");
        n_cmp++;
        if (gpio_out !== 8'hA5) begin
            n_bad++;
            $display("[TB] FAIL gpio_out_tgl got %02h want a5", gpio_out);
        end
        apb_rd(3'd0, 8'hA5, "rd_out");
        apb_rd(3'd1, 8'hF0, "rd_dir");
    endtask

    task automatic test_inputs();
        @(negedge pclk);
        gpio_in = 8'h3C;
        repeat (2) @(negedge pclk);
        apb_rd(3'd2, 8'h3C, "rd_in");
        apb_rd(3'd6, 8'h00, "rd_tgl");
        apb_wr(3'd2, 8'hFF, "wr_in");
        apb_rd(3'd2, 8'h3C, "rd_in_after_wr");
        apb_wr(3'd7, 8'hFF, "wr_id");
        apb_rd(3'd7, 8'(BANK), "rd_id_after_wr");
    endtask

    task automatic test_irq();
        logic [2:0] irq_seen;
        @(negedge pclk);
        gpio_in = 8'h80;
        repeat (6) @(negedge pclk);
        apb_rd(3'd5, 8'h00, "irq_disabled");
        apb_wr(3'd3, 8'h01, "wr_rise_en");
        apb_wr(3'd4, 8'h80, "wr_fall_en");
        @(negedge pclk);
        gpio_in = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            irq_seen[i] = irq;
        end
        n_cmp++;
        if (irq_seen !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL irq_latency got %b want 100", irq_seen);
        end
        apb_rd(3'd5, 8'h81, "irq_stat_81");
        @(negedge pclk);
        gpio_in = 8'h03;
        repeat (5) @(negedge pclk);
        gpio_in = 8'h01;
        repeat (5) @(negedge pclk);
        apb_rd(3'd5, 8'h81, "irq_pin1_ignored");
        apb_wr(3'd3, 8'h00, "clr_rise_en");
        apb_rd(3'd5, 8'h81, "irq_sticky_en");
        apb_wr(3'd3, 8'h01, "set_rise_en");
        apb_wr(3'd5, 8'h01, "w1c_01");
        apb_rd(3'd5, 8'h80, "irq_stat_80");
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL irq_after_w1c01 got %b want 1", irq);
        end
        apb_wr(3'd5, 8'h80, "w1c_80");
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL irq_after_w1c80 got %b want 0", irq);
        end
        apb_rd(3'd5, 8'h00, "irq_stat_00");
    endtask

    task automatic test_set_wins();
        @(negedge pclk);
        gpio_in = 8'h00;
        repeat (5) @(negedge pclk);
        gpio_in = 8'h01;
        repeat (5) @(negedge pclk);
        gpio_in = 8'h00;
        repeat (5) @(negedge pclk);
        apb_rd(3'd5, 8'h01, "pre_set_wins");
        xfer(1'b1, 3'd5, 8'h01, 1'b1, 8'h01, "w1c_race");
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL irq_set_wins got %b want 1", irq);
        end
        apb_rd(3'd5, 8'h01, "set_wins");
    endtask

    task automatic test_abort();
        logic seen;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'hFF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            seen = seen | pready;
        end
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            seen = seen | pready;
        end
        n_cmp++;
        if (seen !== 1'b0 || gpio_out !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL reset_abort got pready_seen=%b out=%02h want 0/00", seen, gpio_out);
        end
        apb_rd(3'd0, 8'h00, "rd_out_after_rst");

        apb_wr(3'd0, 8'h33, "wr_out_33");
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'hCC;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            seen = seen | pready;
        end
        n_cmp++;
        if (seen !== 1'b0 || gpio_out !== 8'h33) begin
            n_bad++;
            $display("[TB] FAIL psel_drop got pready_seen=%b out=%02h want 0/33", seen, gpio_out);
        end
        apb_rd(3'd0, 8'h33, "rd_out_after_drop");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_out_dir();
        test_inputs();
        test_irq();
        test_set_wins();
        test_abort();
        repeat (2) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
